// File: rtl/fpu_addsub_seq_pkg.sv
// Shared types and constants for the sequential floating-point add/sub unit.
package fpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fpu_state_e;

    localparam int ST_EXACT     = 0;
    localparam int ST_OVERFLOW  = 1;
    localparam int ST_UNDERFLOW = 2;
    localparam int ST_INEXACT   = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fpu_addsub_seq_if.sv
// Operand/result handshake bundle between the operand registers and the FPU.
interface fpu_addsub_seq_if #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int DATA_W = 1 + EXP_W + MAN_W
);
    logic              start_in;
    logic              op_in;
    logic [DATA_W-1:0] op_a_in;
    logic [DATA_W-1:0] op_b_in;
    logic              busy_out;
    logic              done_out;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        status_out;

    modport master (
        output start_in, op_in, op_a_in, op_b_in,
        input  busy_out, done_out, data_out, status_out
    );

    modport slave (
        input  start_in, op_in, op_a_in, op_b_in,
        output busy_out, done_out, data_out, status_out
    );
endinterface

// File: rtl/fpu_round_rne.sv
// Combinational round-to-nearest-even of a significand with guard/round/sticky bits.
module fpu_round_rne #(
    parameter int MAN_W = 23
) (
    input  logic [MAN_W:0] i_man,
    input  logic           i_guard,
    input  logic           i_round,
    input  logic           i_sticky,
    output logic [MAN_W:0] o_man,
    output logic           o_carry,
    output logic           o_inexact
);
    logic w_inc;

    // Ties (guard only) round up only when the kept lsb is odd.
    assign w_inc                = i_guard & (i_round | i_sticky | i_man[0]);
    assign {o_carry, o_man}     = {1'b0, i_man} + {{(MAN_W+1){1'b0}}, w_inc};
    assign o_inexact            = i_guard | i_round | i_sticky;
endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor: align, add, iterative normalise, RNE round.
module fpu_addsub_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clock100KHz,
    input  logic              reset,
    fpu_addsub_seq_if.slave   bus
);
    localparam int              FW      = MAN_W + 4;
    localparam logic [EXP_W:0]  EXP_ONE = (EXP_W+1)'(1);
    localparam logic [EXP_W:0]  EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [3:0]      S_EXACT = 4'(1 << ST_EXACT);
    localparam logic [3:0]      S_OVF   = 4'(1 << ST_OVERFLOW);
    localparam logic [3:0]      S_UNF   = 4'(1 << ST_UNDERFLOW);
    localparam logic [3:0]      S_INX   = 4'(1 << ST_INEXACT);

    fpu_state_e        r_state;
    logic              r_busy, r_done;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_status;

    logic [DATA_W-1:0] r_a_p0, r_b_p0;
    logic              r_op_p0;
    logic              r_sign_p1, r_sub_p1;
    logic [FW-1:0]     r_big_p1, r_sml_p1;
    logic [EXP_W:0]    r_exp;
    logic [FW:0]       r_sum_p2;
    logic              r_uf_p2;
    logic [DATA_W-1:0] r_res;
    logic [3:0]        r_stat;

    logic              w_sa, w_sb, w_a_ge_b, w_big_sign, w_sml_sign;
    logic [EXP_W-1:0]  w_ea, w_eb, w_big_exp, w_sml_exp, w_shamt;
    logic [MAN_W:0]    w_siga, w_sigb, w_big_sig, w_sml_sig;
    logic [2*FW-1:0]   w_wide;
    logic [FW-1:0]     w_sml_al;
    logic [FW:0]       w_sum;
    logic [MAN_W:0]    w_rnd_man;
    logic              w_rnd_carry, w_rnd_inexact;
    logic [EXP_W:0]    w_exp_fin;

    assign w_sa   = r_a_p0[DATA_W-1];
    assign w_sb   = (r_op_p0 == OP_SUB) ? ~r_b_p0[DATA_W-1] : r_b_p0[DATA_W-1];
    assign w_ea   = r_a_p0[DATA_W-2:MAN_W];
    assign w_eb   = r_b_p0[DATA_W-2:MAN_W];
    assign w_siga = (w_ea == '0) ? '0 : {1'b1, r_a_p0[MAN_W-1:0]};
    assign w_sigb = (w_eb == '0) ? '0 : {1'b1, r_b_p0[MAN_W-1:0]};

    // Zero operands compare as zero magnitude regardless of their mantissa field.
    assign w_a_ge_b   = {w_ea, w_siga[MAN_W-1:0]} >= {w_eb, w_sigb[MAN_W-1:0]};
    assign w_big_sign = w_a_ge_b ? w_sa   : w_sb;
    assign w_sml_sign = w_a_ge_b ? w_sb   : w_sa;
    assign w_big_exp  = w_a_ge_b ? w_ea   : w_eb;
    assign w_sml_exp  = w_a_ge_b ? w_eb   : w_ea;
    assign w_big_sig  = w_a_ge_b ? w_siga : w_sigb;
    assign w_sml_sig  = w_a_ge_b ? w_sigb : w_siga;
    assign w_shamt    = w_big_exp - w_sml_exp;
    assign w_wide     = {w_sml_sig, 3'b000, {FW{1'b0}}} >> w_shamt;
    assign w_sml_al   = (32'(w_shamt) >= FW - 1) ? {{(FW-1){1'b0}}, |w_sml_sig}
                      : {w_wide[2*FW-1:FW+1], w_wide[FW] | (|w_wide[FW-1:0])};

    assign w_sum = r_sub_p1 ? ({1'b0, r_big_p1} - {1'b0, r_sml_p1})
                            : ({1'b0, r_big_p1} + {1'b0, r_sml_p1});

    fpu_round_rne #(.MAN_W(MAN_W)) u_round (
        .i_man     (r_sum_p2[FW-1:3]),
        .i_guard   (r_sum_p2[2]),
        .i_round   (r_sum_p2[1]),
        .i_sticky  (r_sum_p2[0]),
        .o_man     (w_rnd_man),
        .o_carry   (w_rnd_carry),
        .o_inexact (w_rnd_inexact)
    );

    assign w_exp_fin = r_exp + {{EXP_W{1'b0}}, w_rnd_carry};

    always_ff @(posedge clock100KHz) begin
        case (r_state)
            IDLE: if (bus.start_in) begin
                r_a_p0  <= bus.op_a_in;
                r_b_p0  <= bus.op_b_in;
                r_op_p0 <= bus.op_in;
            end
            // ---- stage p1: operands ordered and aligned
            ALIGN: begin
                r_sign_p1 <= w_big_sign;
                r_sub_p1  <= w_big_sign ^ w_sml_sign;
                r_exp     <= {1'b0, w_big_exp};
                r_big_p1  <= {w_big_sig, 3'b000};
                r_sml_p1  <= w_sml_al;
                r_uf_p2   <= 1'b0;
            end
            // ---- stage p2: raw sum, normalised in place
            ADD: begin
                r_sum_p2 <= w_sum;
                r_res    <= '0;
                r_stat   <= S_EXACT;
            end
            NORM: begin
                if (r_sum_p2[FW]) begin
                    r_sum_p2 <= {1'b0, r_sum_p2[FW:2], r_sum_p2[1] | r_sum_p2[0]};
                    r_exp    <= r_exp + EXP_ONE;
                end else if (!r_sum_p2[FW-1]) begin
                    if (r_exp == EXP_ONE) r_uf_p2 <= 1'b1;
                    else begin
                        r_sum_p2 <= r_sum_p2 << 1;
                        r_exp    <= r_exp - EXP_ONE;
                    end
                end
            end
            ROUND: begin
                if (r_uf_p2) begin
                    r_res  <= {r_sign_p1, {(DATA_W-1){1'b0}}};
                    r_stat <= S_UNF;
                end else if (w_exp_fin > EXP_MAX) begin
                    r_res  <= {r_sign_p1, {(DATA_W-1){1'b1}}};
                    r_stat <= S_OVF;
                end else begin
                    r_res  <= {r_sign_p1, w_exp_fin[EXP_W-1:0], w_rnd_man[MAN_W-1:0]};
                    r_stat <= w_rnd_inexact ? S_INX : S_EXACT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock100KHz) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= '0;
            r_status <= S_EXACT;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start_in) begin
                    r_busy  <= 1'b1;
                    r_state <= ALIGN;
                end
                ALIGN: r_state <= ADD;
                ADD:   r_state <= (w_sum == '0) ? DONE : NORM;
                NORM:  if (r_sum_p2[FW] || r_sum_p2[FW-1] || r_exp == EXP_ONE) r_state <= ROUND;
                ROUND: r_state <= DONE;
                DONE: begin
                    r_data   <= r_res;
                    r_status <= r_stat;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy_out   = r_busy;
    assign bus.done_out   = r_done;
    assign bus.data_out   = r_data;
    assign bus.status_out = r_status;
endmodule

// File: doc/fpu_addsub_seq.md
Name: fpu_addsub_seq

Overview:
Parametrised, multi-cycle floating-point adder/subtractor for the custom sign/exponent/mantissa format used across the datapath. It replaces the single-width FPU stub and adds the following:
- generic exponent and mantissa widths
- a start/done handshake
- round-to-nearest-even
- one-hot status flags

It sits between the operand registers and the result/status display logic, clocked by the 100 kHz system clock.

Parameters:
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa width; hidden bit is implicit.
- DATA_W, 1+EXP_W+MAN_W: total operand width; derived, do not override.

Ports:
- clock100KHz  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start_in  in  1  request; sampled only in IDLE.
- op_in  in  1  0 = A+B, 1 = A-B.
- op_a_in  in  DATA_W  operand A: {sign, exponent, mantissa}.
- op_b_in  in  DATA_W  operand B, same layout.
- busy_out  out  1  high from the cycle after an accepted start until done.
- done_out  out  1  one-cycle pulse when the result is valid.
- data_out  out  DATA_W  result; held until the next done.
- status_out  out  4  one-hot {INEXACT, UNDERFLOW, OVERFLOW, EXACT}; held with data_out.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FSM goes to IDLE; busy_out=0, done_out=0, data_out=0, status_out=4'b0001.
  - Reset mid-operation aborts the operation. No done pulse follows.
- Operands are latched on the accepted start (IDLE and start_in=1). start_in while busy is ignored.
- Operand encoding:
  - exponent 0 = zero; the mantissa is ignored and there is no denormal support.
  - All other exponents, including all-ones, are normal. There is no inf/NaN.
- FSM:
  - IDLE -> ALIGN on start.
  - ALIGN (1 cycle):
    - Effective B sign = sign_b XOR op_in.
    - Swap so |A| >= |B|, comparing exponent then mantissa.
    - Right-shift the smaller significand by the exponent difference into a MAN_W+4 bit field {1.hidden, mantissa, guard, round, sticky}.
    - Shifts >= MAN_W+3 leave only the sticky bit.
  - ADD (1 cycle):
    - Add or subtract significands per effective signs; result sign = sign of the larger operand.
    - Zero sum: result = +0 with EXACT flag; go straight to DONE.
  - NORM, iterative:
    - On carry-out, shift right by 1 and increment the exponent in the same cycle.
    - Otherwise shift left 1 bit per cycle, decrementing the exponent, until the hidden bit = 1.
    - At most MAN_W+3 cycles.
    - If the exponent would go below 1, go to ROUND with an underflow mark.
  - ROUND (1 cycle):
    - Round-to-nearest-even using guard, round and sticky.
    - A mantissa carry-out renormalises with exponent+1.
    - Overflow (exponent > 2^EXP_W-1): saturate to {sign, all-ones exponent, all-ones mantissa} and set OVERFLOW.
    - Underflow: result = signed zero and set UNDERFLOW.
    - Otherwise set INEXACT if any of guard/round/sticky was nonzero, else EXACT.
  - DONE (1 cycle): register data_out/status_out, pulse done_out, deassert busy_out, return to IDLE.
- Latency from the start edge to the done pulse:
  - Minimum 5 cycles.
  - Maximum 5+MAN_W+3 cycles.
  - Zero result: 3 cycles.
- Exactly one status bit is set at any time. OVERFLOW and UNDERFLOW take priority over INEXACT.
- A start is accepted in the IDLE cycle immediately after DONE, so back-to-back operations are allowed.

Decomposition:
- Package fpu_pkg holds:
  - the state enum (IDLE, ALIGN, ADD, NORM, ROUND, DONE)
  - status bit index constants: ST_EXACT=0, ST_OVERFLOW=1, ST_UNDERFLOW=2, ST_INEXACT=3
  - op encoding constants OP_ADD=0, OP_SUB=1
- One sub-module, fpu_round_rne: combinational rounding of {mantissa, guard, round, sticky} -> rounded mantissa, carry, inexact. It is reused by future multiply units.

Test Plan:
1. 0x3F800000 + 0x3F800000, op=0 -> data_out=0x40000000, status=EXACT, done exactly 5 cycles after start.
2. 0x3F800000 - 0x3F800000, op=1 -> data_out=0x00000000, status=EXACT, done 3 cycles after start; also check 0x00800001 - 0x00800000 -> 0x00000000, UNDERFLOW.
3. 0x3F800000 + 0x33800000 (tie at 2^-24) -> 0x3F800000, INEXACT (rounds to even); 0x3F800001 + 0x33800000 -> 0x3F800002, INEXACT.
4. 0x7FFFFFFF + 0x7FFFFFFF -> 0x7FFFFFFF, OVERFLOW; 0xFFFFFFFF + 0xFFFFFFFF -> 0xFFFFFFFF, OVERFLOW.
5. Cancellation 0x3F800001 - 0x3F800000 -> 0x34000000, EXACT, latency 5+23 cycles (maximum normalisation).
6. Pulse start_in again while busy, then drive reset=0 for one edge mid-NORM -> second start ignored; after reset busy=0, done never pulses, data_out=0, status=EXACT; the next start completes normally.
